// File: rtl/csync_sync_ctrl.sv
// csync_sync_ctrl: qualifies console vsync timing and switches the csync generator into predictive mode
module csync_sync_ctrl #(
  parameter int LINE_W      = 11,
  parameter int LINES_W     = 9,
  parameter int VSYNC_LINES = 3,
  parameter int MIN_LINE    = 600,
  parameter int MAX_LINE    = 1000,
  parameter int TOL         = 3,
  parameter int LOCK_FRAMES = 2,
  parameter int LOSS_FRAMES = 2,
  parameter int MAX_LINES   = 400
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vsync,
  output logic [LINE_W-1:0]  line_period,
  output logic [LINES_W-1:0] frame_lines,
  output logic               mode_sel,
  output logic               locked,
  output logic               frame_start,
  output logic               err
);
  localparam int PW  = $clog2(VSYNC_LINES * MAX_LINE + 2);
  localparam int GW  = $clog2(LOCK_FRAMES + 1);
  localparam int MW  = $clog2(LOSS_FRAMES + 1);
  localparam int SAT = VSYNC_LINES * MAX_LINE + 1;
  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;
  state_t state, state_n;
  logic vs1, vs2, fall, rise;
  logic [PW-1:0] pcnt;
  logic [LINE_W-1:0] phase, cand;
  logic [LINES_W-1:0] line_cnt, meas;
  logic [GW-1:0] good_cnt, good_n;
  logic [MW-1:0] miss_cnt, miss_n;
  logic [31:0] p32, ph32, lp32, lc32;
  logic pulse_ok, rise_ok, phase_lo, phase_ok, fall_ok, wrap, timeout, bad;
  logic err_n, fs_n, ld_lp, ld_fl;
  assign fall     = vs2 & ~vs1;
  assign rise     = ~vs2 & vs1;
  assign p32      = 32'(pcnt);
  assign ph32     = 32'(phase);
  assign lp32     = 32'(line_period);
  assign lc32     = 32'(line_cnt);
  assign pulse_ok = p32 >= VSYNC_LINES * MIN_LINE && p32 <= VSYNC_LINES * MAX_LINE;
  assign cand     = LINE_W'(p32 / VSYNC_LINES);
  assign rise_ok  = pulse_ok && 32'(cand) + TOL >= lp32 && lp32 + TOL >= 32'(cand);
  assign phase_lo = ph32 <= TOL;
  assign phase_ok = phase_lo || ph32 + TOL >= lp32;
  assign meas     = phase_lo ? line_cnt : line_cnt + 1'b1;
  assign fall_ok  = phase_ok && (meas == frame_lines || (state == TRACK && good_cnt == '0));
  assign wrap     = ph32 + 1 == lp32;
  assign timeout  = state != SEARCH && vs1 && vs2 && lc32 > MAX_LINES;
  assign bad      = (rise && !rise_ok) || (fall && !fall_ok);
  assign locked   = state == LOCKED;
  assign mode_sel = locked;
  always_comb begin
    state_n = state;
    good_n  = good_cnt;
    miss_n  = miss_cnt;
    err_n   = 1'b0;
    fs_n    = 1'b0;
    ld_lp   = 1'b0;
    ld_fl   = 1'b0;
    if (timeout) begin
      err_n   = 1'b1;
      state_n = SEARCH;
    end else begin
      case (state)
        SEARCH: if (rise) begin
          err_n   = !pulse_ok;
          ld_lp   = pulse_ok;
          state_n = pulse_ok ? TRACK : SEARCH;
          good_n  = '0;
          miss_n  = '0;
        end
        TRACK: begin
          fs_n = fall;
          if (bad) begin
            err_n   = 1'b1;
            state_n = SEARCH;
          end else if (fall) begin
            ld_fl   = 1'b1;
            good_n  = good_cnt + 1'b1;
            state_n = 32'(good_cnt) + 1 == LOCK_FRAMES ? LOCKED : TRACK;
          end
        end
        LOCKED: begin
          fs_n = fall;
          if (bad) begin
            err_n   = 1'b1;
            miss_n  = miss_cnt + 1'b1;
            state_n = 32'(miss_cnt) + 1 == LOSS_FRAMES ? SEARCH : LOCKED;
          end else if (fall) begin
            miss_n = '0;
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs1         <= 1'b1;
      vs2         <= 1'b1;
      pcnt        <= '0;
      phase       <= '0;
      line_cnt    <= '0;
      good_cnt    <= '0;
      miss_cnt    <= '0;
      state       <= SEARCH;
      line_period <= '0;
      frame_lines <= '0;
      frame_start <= 1'b0;
      err         <= 1'b0;
    end else begin
      vs1 <= vsync;
      vs2 <= vs1;
      if (!vs1) pcnt <= fall ? PW'(1) : (p32 == SAT ? pcnt : pcnt + 1'b1);
      if (rise) begin
        phase    <= '0;
        line_cnt <= LINES_W'(VSYNC_LINES);
      end else if (vs1 && state != SEARCH) begin
        phase    <= wrap ? '0 : phase + 1'b1;
        line_cnt <= line_cnt + LINES_W'(wrap);
      end
      state       <= state_n;
      good_cnt    <= good_n;
      miss_cnt    <= miss_n;
      frame_start <= fs_n;
      err         <= err_n;
      if (ld_lp) line_period <= cand;
      if (ld_fl) frame_lines <= meas;
    end
  end
endmodule

// File: tb/tb_csync_sync_ctrl.sv
// tb_csync_sync_ctrl: scaled-timing bench with a frame-level reference model
module tb_csync_sync_ctrl;
  localparam int LW = 11, NW = 9, VL = 3, MINL = 20, MAXL = 40, TOL = 3;
  localparam int LOCKF = 2, LOSSF = 2, MAXN = 40;
  logic clk = 1'b0, rst_n = 1'b0, vsync = 1'b1;
  logic [LW-1:0] line_period;
  logic [NW-1:0] frame_lines;
  logic mode_sel, locked, frame_start, err;
  int checks = 0, errors = 0, n_err = 0, n_fs = 0;
  bit mon_en = 1'b0;
  int s1 = 1, s2 = 1, lo_len = 0, hi_len = 0, e_lp = 0, e_fl = 0, good = 0, miss = 0;
  bit trk = 1'b0, lck = 1'b0, e_err = 1'b0, e_fs = 1'b0;

  csync_sync_ctrl #(
    .LINE_W(LW), .LINES_W(NW), .VSYNC_LINES(VL), .MIN_LINE(MINL), .MAX_LINE(MAXL),
    .TOL(TOL), .LOCK_FRAMES(LOCKF), .LOSS_FRAMES(LOSSF), .MAX_LINES(MAXN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .line_period(line_period),
    .frame_lines(frame_lines), .mode_sel(mode_sel), .locked(locked),
    .frame_start(frame_start), .err(err)
  );

  always #5 clk = ~clk;

  // Reference: pulse length and line count come straight from run lengths of the sampled vsync
  always @(posedge clk) begin : model
    int cand, lines, ph, meas;
    bit fall, rise, pok, phok, ok;
    if (!rst_n) begin
      s1 = 1; s2 = 1; lo_len = 0; hi_len = 0; e_lp = 0; e_fl = 0; good = 0; miss = 0;
      trk = 0; lck = 0; e_err = 0; e_fs = 0; mon_en = 1;
    end else begin
      fall = s2 == 1 && s1 == 0;
      rise = s2 == 0 && s1 == 1;
      e_err = 0;
      e_fs = 0;
      pok = lo_len >= VL * MINL && lo_len <= VL * MAXL;
      cand = lo_len / VL;
      lines = e_lp != 0 ? VL + hi_len / e_lp : 0;
      ph = e_lp != 0 ? hi_len % e_lp : 0;
      phok = ph <= TOL || ph >= e_lp - TOL;
      meas = ph <= TOL ? lines : lines + 1;
      if (trk && s1 == 1 && s2 == 1 && lines > MAXN) begin
        e_err = 1; trk = 0; lck = 0;
      end else if (rise && !trk) begin
        if (pok) begin
          e_lp = cand; trk = 1; good = 0; miss = 0;
        end else e_err = 1;
      end else if ((rise || fall) && trk) begin
        e_fs = fall;
        ok = rise ? (pok && (cand > e_lp ? cand - e_lp : e_lp - cand) <= TOL)
                  : (phok && (meas == e_fl || (!lck && good == 0)));
        if (!ok) begin
          e_err = 1;
          miss++;
          if (!lck || miss == LOSSF) begin trk = 0; lck = 0; end
        end else if (fall) begin
          miss = 0;
          if (!lck) begin e_fl = meas; good++; lck = good == LOCKF; end
        end
      end
      if (s1 == 0) lo_len = fall ? 1 : (lo_len < VL * MAXL + 1 ? lo_len + 1 : lo_len);
      hi_len = rise ? 0 : hi_len + s1;
      s2 = s1;
      s1 = int'(vsync);
    end
  end

  always @(negedge clk) if (mon_en) begin
    checks++;
    if ({line_period, frame_lines, mode_sel, locked, frame_start, err} !==
        {LW'(e_lp), NW'(e_fl), lck, lck, e_fs, e_err}) begin
      errors++;
      $display("FAIL outputs t=%0t got lp=%0d fl=%0d mode=%b lock=%b fs=%b err=%b want lp=%0d fl=%0d mode=%b lock=%b fs=%b err=%b",
               $time, line_period, frame_lines, mode_sel, locked, frame_start, err,
               e_lp, e_fl, lck, lck, e_fs, e_err);
    end
    if (err === 1'b1) n_err++;
    if (frame_start === 1'b1) n_fs++;
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic lvl(input bit v, input int n);
    vsync = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input int hi, input int lo);
    lvl(1'b1, hi);
    lvl(1'b0, lo);
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int lo, hi;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_lp", int'(line_period), 0);
    chk("reset_lock", int'(locked), 0);
    chk("reset_mode", int'(mode_sel), 0);
    lvl(1'b0, 130);
    frame(810, 90);
    chk("long_pulse_err", n_err, 1);
    chk("long_pulse_lp", int'(line_period), 0);
    chk("long_pulse_lock", int'(locked), 0);
    frame(810, 90);
    chk("track_lp", int'(line_period), 30);
    chk("track_fl", int'(frame_lines), 30);
    chk("track_unlocked", int'(locked), 0);
    frame(810, 90);
    chk("lock", int'(locked), 1);
    chk("lock_mode", int'(mode_sel), 1);
    chk("lock_fs", n_fs, 2);
    chk("lock_no_err", n_err, 1);
    frame(780, 90);
    chk("short_err", n_err, 2);
    chk("short_keeps_lock", int'(locked), 1);
    frame(810, 90);
    chk("recover_no_err", n_err, 2);
    frame(780, 90);
    frame(780, 90);
    chk("loss_lock", int'(locked), 0);
    chk("loss_mode", int'(mode_sel), 0);
    chk("loss_err", n_err, 4);
    frame(810, 90);
    frame(810, 90);
    chk("relock", int'(locked), 1);
    frame(808, 90);
    chk("early2_ok", n_err, 4);
    frame(800, 90);
    chk("early10_err", n_err, 5);
    chk("early10_lock", int'(locked), 1);
    frame(810, 90);
    lvl(1'b1, 1400);
    chk("timeout_err", n_err, 6);
    chk("timeout_unlock", int'(locked), 0);
    lvl(1'b0, 90);
    frame(810, 90);
    frame(810, 90);
    chk("relock2", int'(locked), 1);
    lvl(1'b1, 400);
    rst_pulse();
    chk("rst_lp", int'(line_period), 0);
    chk("rst_fl", int'(frame_lines), 0);
    chk("rst_lock", int'(locked), 0);
    chk("rst_mode", int'(mode_sel), 0);
    chk("rst_fs", int'(frame_start), 0);
    chk("rst_err", int'(err), 0);
    lvl(1'b1, 410);
    lvl(1'b0, 90);
    frame(810, 90);
    chk("post_rst_track", int'(locked), 0);
    frame(810, 90);
    chk("post_rst_lock", int'(locked), 1);
    for (int i = 0; i < 40; i++) begin
      hi = ($urandom_range(0, 7) == 0 ? 26 : 27) * 30 + int'($urandom_range(0, 14)) - 12;
      lo = $urandom_range(0, 9) == 0 ? ($urandom_range(0, 1) == 1 ? 40 : 130)
                                     : int'($urandom_range(84, 96));
      if ($urandom_range(0, 19) == 0) rst_pulse();
      frame(hi, lo);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
